// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider.
// Holds the FSM state codes, start/ready level names, data widths and small helpers.
// The DIV_RADIX4_EN macro is consumed by div_iter.sv; nothing here depends on it.
package div_iter_pkg;

  localparam int unsigned WordW   = 32;
  localparam int unsigned ResultW = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [WordW-1:0] ZeroWord = '0;

  // Magnitude of an operand. For 0x80000000 the result is 0x80000000 read as
  // unsigned, so the most negative value has no overflow.
  function automatic logic [WordW-1:0] abs_word(input logic [WordW-1:0] v,
                                                input logic             is_signed);
    return (is_signed && v[WordW-1]) ? (~v + 32'd1) : v;
  endfunction

  // Two's-complement negate when neg is set; wraps modulo 2^32.
  function automatic logic [WordW-1:0] neg_if(input logic [WordW-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// EX <-> divider request/response bundle.
// master (EX side): drives signed_div_i, opdata1_i, opdata2_i, start_i, annul_i;
//                   receives result_o {remainder, quotient} and the one-cycle ready_o pulse.
// slave (divider side): the mirror image.
interface div_iter_if;
  import div_iter_pkg::*;

  logic               signed_div_i;
  logic [WordW-1:0]   opdata1_i;
  logic [WordW-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [ResultW-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_iter_step.sv
// One restoring shift-subtract step of the divider (combinational).
// work_i    : 65-bit working value {partial remainder, dividend/quotient bits}
// divisor_i : 32-bit divisor magnitude
// work_o    : working value shifted left by one with the new quotient bit in bit 0
module div_iter_step
  import div_iter_pkg::*;
(
  input  logic [64:0]      work_i,
  input  logic [WordW-1:0] divisor_i,
  output logic [64:0]      work_o
);

  // work_i[64] is always zero, so work_i[64:31] is the shifted upper 33 bits
  // zero-extended to 34; bit 33 of the difference is the borrow.
  logic [33:0] diff;

  always_comb begin
    diff = work_i[64:31] - {2'b00, divisor_i};
    if (!diff[33]) begin
      work_o = {diff[32:0], work_i[30:0], 1'b1};
    end else begin
      work_o = {work_i[63:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit DIV/DIVU unit for the EX stage.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   div_io : div_iter_if.slave -- operands, start/annul in; {rem, quo} result and
//            one-cycle ready pulse out
// Configuration: define DIV_RADIX4_EN to retire two quotient bits per cycle
// (two chained steps, 16 iterations); results are identical either way.
module div_iter
  import div_iter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  div_io
);

`ifdef DIV_RADIX4_EN
  localparam logic [5:0] StepsPerEdge = 6'd2;
`else
  localparam logic [5:0] StepsPerEdge = 6'd1;
`endif

  div_state_e         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [64:0]        work_q, work_d;
  logic [WordW-1:0]   divisor_q, divisor_d;
  logic               quo_neg_q, quo_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic [ResultW-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [64:0]        work_next;
  logic [5:0]         cnt_step;
  logic               abort;
  logic               unused_work_msb;

`ifdef DIV_RADIX4_EN
  logic [64:0] work_mid;

  div_iter_step u_step0 (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_mid)
  );

  div_iter_step u_step1 (
    .work_i    (work_mid),
    .divisor_i (divisor_q),
    .work_o    (work_next)
  );
`else
  div_iter_step u_step0 (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_next)
  );
`endif

  assign cnt_step        = cnt_q + StepsPerEdge;
  assign abort           = div_io.annul_i || (div_io.start_i == DivStop);
  // After the last step the top bit is always zero.
  assign unused_work_msb = work_next[64];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    result_d  = result_q;
    ready_d   = DivResultNotReady;

    unique case (state_q)
      DivFree: begin
        if ((div_io.start_i == DivStart) && !div_io.annul_i) begin
          if (div_io.opdata2_i == ZeroWord) begin
            state_d = DivByZero;
            dz_d    = 1'b1;
          end else begin
            state_d   = DivOn;
            dz_d      = 1'b0;
            cnt_d     = '0;
            divisor_d = abs_word(div_io.opdata2_i, div_io.signed_div_i);
            work_d    = {33'b0, abs_word(div_io.opdata1_i, div_io.signed_div_i)};
            quo_neg_d = div_io.signed_div_i &
                        (div_io.opdata1_i[WordW-1] ^ div_io.opdata2_i[WordW-1]);
            rem_neg_d = div_io.signed_div_i & div_io.opdata1_i[WordW-1];
          end
        end
      end

      DivByZero: begin
        if (abort) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = {ZeroWord, ZeroWord};
        end
      end

      DivOn: begin
        if (abort) begin
          state_d = DivFree;
        end else begin
          work_d = work_next;
          cnt_d  = cnt_step;
          if (cnt_step == 6'd32) begin
            result_d = {neg_if(work_next[63:32], rem_neg_q), neg_if(work_next[31:0], quo_neg_q)};
            ready_d  = DivResultReady;
            state_d  = DivEnd;
          end
        end
      end

      DivEnd: begin
        // Divide-by-zero loads its zero result on entry and pulses ready here,
        // one edge later than a normal completion.
        state_d = DivFree;
        ready_d = dz_q ? DivResultReady : DivResultNotReady;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign div_io.result_o = result_q;
  assign div_io.ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vectors with hand-computed results,
// plus a transaction-level reference model compared against the outputs every cycle.
module tb_div_iter;

`ifdef DIV_RADIX4_EN
  localparam int Lat = 16;
`else
  localparam int Lat = 32;
`endif

  logic clk;
  logic rst;

  div_iter_if bus ();

  div_iter dut (
    .clk    (clk),
    .rst    (rst),
    .div_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit sim_done = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference quotient/remainder by plain integer arithmetic (truncating division).
  function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sg) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction timeline model: acceptance edge, abort window, completion edge.
  int          cyc = 0, acc_edge = 0, done_edge = 0, free_edge = 0;
  bit          busy = 1'b0, m_dz = 1'b0, m_ready = 1'b0;
  logic [63:0] m_result = 64'h0, pend = 64'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     = 1'b0;
      m_ready  = 1'b0;
      m_result = 64'h0;
    end else begin
      cyc++;
      m_ready = 1'b0;
      if (busy && cyc == free_edge) busy = 1'b0;
      if (!busy) begin
        if (bus.start_i && !bus.annul_i) begin
          busy      = 1'b1;
          acc_edge  = cyc;
          m_dz      = (bus.opdata2_i == 32'h0);
          pend      = ref_div(bus.signed_div_i, bus.opdata1_i, bus.opdata2_i);
          done_edge = acc_edge + (m_dz ? 2 : Lat);
          free_edge = m_dz ? acc_edge + 3 : acc_edge + Lat + 2;
        end
      end else if ((m_dz ? (cyc == acc_edge + 1) : (cyc <= done_edge)) &&
                   (bus.annul_i || !bus.start_i)) begin
        busy = 1'b0;
      end else if (m_dz && cyc == acc_edge + 1) begin
        m_result = 64'h0;
      end else if (cyc == done_edge) begin
        m_result = pend;
        m_ready  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!sim_done) begin
      check("ready_o vs model", {63'b0, bus.ready_o}, {63'b0, m_ready});
      check("result_o vs model", bus.result_o, m_result);
    end
  end

  // Starts one division after two idle cycles and measures edges from acceptance to the
  // ready pulse. With hold set, start_i stays high after the pulse.
  task automatic run_div(input string name, input bit sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat,
                         input bit hold);
    int got;
    got = -1;
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        got = i - 1;
        break;
      end
    end
    if (!hold) bus.start_i = 1'b0;
    check({name, " latency"}, 64'(got), 64'(lat));
    check({name, " result"}, bus.result_o, exp);
    check({name, " model"}, m_result, exp);
  endtask

  initial begin
    int got;
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h0;
    bus.opdata2_i    = 32'h0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1;
    check("reset result", bus.result_o, 64'h0);
    check("reset ready", {63'b0, bus.ready_o}, 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_div("u 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, Lat, 1'b0);
    run_div("s -7/2", 1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, Lat, 1'b0);
    run_div("u ffffffff/1", 1'b0, 32'hFFFFFFFF, 32'h1, 64'h00000000_FFFFFFFF, Lat, 1'b0);
    run_div("u 5/0", 1'b0, 32'd5, 32'd0, 64'h0, 2, 1'b0);
    run_div("s min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, Lat, 1'b0);

    // Annul at edge N+10: no pulse, result keeps the previous value.
    repeat (2) @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("annul no ready", {63'b0, bus.ready_o}, 64'h0);
      check("annul result kept", bus.result_o, 64'h00000000_80000000);
    end
    run_div("u 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, Lat, 1'b0);

    // Back-to-back: start held through the pulse, new operands for the second division.
    run_div("b2b first", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, Lat, 1'b1);
    bus.opdata1_i = 32'd20;
    bus.opdata2_i = 32'd6;
    @(negedge clk);
    check("b2b gap ready low", {63'b0, bus.ready_o}, 64'h0);
    got = -1;
    for (int j = 2; j <= 100; j++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        got = j;
        break;
      end
    end
    bus.start_i = 1'b0;
    check("b2b second spacing", 64'(got), 64'(Lat + 2));
    check("b2b second result", bus.result_o, 64'h00000002_00000003);

    // Asynchronous reset in the middle of an iteration.
    repeat (2) @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async reset result", bus.result_o, 64'h0);
    check("async reset ready", {63'b0, bus.ready_o}, 64'h0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_div("after reset 1000/10", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, Lat, 1'b0);

    repeat (3) @(negedge clk);
    sim_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
